// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers,
// with a watchdog that abandons a start the transmitter never acknowledges.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      active,
    output logic                      timeout_err
);

    localparam int          WD_W = $clog2(TIMEOUT + 1);
    localparam int unsigned N    = NUM_REQ;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [WD_W-1:0] watchdog;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            transfer;

    // Scan starts just past the last grant so every requester gets a turn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = ID_W'((32'(last_grant) + i) % N);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !tx_busy) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign active   = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            watchdog    <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
        end else begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        tx_data    <= req_data[winner*DATA_W +: DATA_W];
                        grant_id   <= winner;
                        last_grant <= winner;
                        tx_start   <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    watchdog <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // An acknowledge in the final watchdog cycle still wins over the abort.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else if (watchdog != '1) begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table plus hand-written
// sequences for long busy, watchdog abort, mid-frame reset and round-robin order.
module tb_uart_tx_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_W (8),
        .ID_W   (2),
        .TIMEOUT(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active),
        .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] v;
        logic       busy;
        logic [3:0] rdy;
        logic       st;
        logic [7:0] d;
        logic [1:0] id;
        logic       act;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got hang expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] rr_exp[5];
        logic       seen;

        // Cycle-by-cycle after reset; data bytes are {44,33,22,A5}.
        vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0, 1'b1};
        vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b1};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b1};
        vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b1};
        vecs[5]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 8'hA5, 2'd0, 1'b0};
        vecs[6]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b1};
        vecs[7]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b1};
        vecs[8]  = '{4'b1010, 1'b0, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b1};
        vecs[9]  = '{4'b1010, 1'b0, 4'b1000, 1'b0, 8'h33, 2'd2, 1'b0};
        vecs[10] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3, 1'b1};
        vecs[11] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3, 1'b1};
        vecs[12] = '{4'b1010, 1'b0, 4'b0000, 1'b0, 8'h44, 2'd3, 1'b1};
        vecs[13] = '{4'b1010, 1'b0, 4'b0010, 1'b0, 8'h44, 2'd3, 1'b0};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b1};
        vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b1};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b1};
        vecs[17] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b0};
        vecs[18] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b0};
        vecs[19] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 8'h22, 2'd1, 1'b0};
        vecs[20] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b1};
        vecs[21] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b1};
        vecs[22] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b1};
        vecs[23] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b0};

        rr_exp[0] = 8'h11; rr_exp[1] = 8'h22; rr_exp[2] = 8'h33;
        rr_exp[3] = 8'h44; rr_exp[4] = 8'h11;

        reset     = 1'b0;
        req_valid = 4'b0000;
        req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
        tx_busy   = 1'b0;
        repeat (3) next();
        @(negedge clock);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        next();
        reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            req_valid = vecs[i].v;
            tx_busy   = vecs[i].busy;
            @(negedge clock);
            check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'(vecs[i].st));
            check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].d));
            check($sformatf("vec%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].id));
            check($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].act));
            check($sformatf("vec%0d_timeout_err", i), 32'(timeout_err), 32'd0);
            next();
        end

        // Single request with a 20-cycle frame.
        req_valid = 4'b0001;
        @(negedge clock);
        check("single_ready", 32'(req_ready), 32'b0001);
        next();
        req_valid = 4'b0000;
        @(negedge clock);
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_id", 32'(grant_id), 32'd0);
        for (int k = 0; k < 20; k++) begin
            next();
            tx_busy = 1'b1;
            @(negedge clock);
            check($sformatf("single_busy%0d_active", k), 32'(active), 32'd1);
            check($sformatf("single_busy%0d_start", k), 32'(tx_start), 32'd0);
        end
        next();
        tx_busy = 1'b0;
        @(negedge clock);
        check("single_done_active", 32'(active), 32'd1);
        next();
        @(negedge clock);
        check("single_idle_active", 32'(active), 32'd0);
        next();

        // Watchdog: START at cycle t, 8 WAIT_BUSY cycles, registered pulse in cycle t+9.
        req_valid = 4'b0001;
        @(negedge clock);
        check("wd_ready", 32'(req_ready), 32'b0001);
        next();
        req_valid = 4'b0000;
        @(negedge clock);
        check("wd_start", 32'(tx_start), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            next();
            @(negedge clock);
            check($sformatf("wd_t%0d_timeout_err", k), 32'(timeout_err), 32'(k == 9));
            check($sformatf("wd_t%0d_active", k), 32'(active), 32'(k < 9));
        end
        next();
        req_valid = 4'b0010;
        @(negedge clock);
        check("wd_after_terr_clear", 32'(timeout_err), 32'd0);
        check("wd_after_ready", 32'(req_ready), 32'b0010);
        next();
        req_valid = 4'b0000;
        @(negedge clock);
        check("wd_after_start", 32'(tx_start), 32'd1);
        check("wd_after_id", 32'(grant_id), 32'd1);
        check("wd_after_data", 32'(tx_data), 32'h22);
        next();
        tx_busy = 1'b1;
        next();
        tx_busy = 1'b0;
        next();
        @(negedge clock);
        check("wd_after_idle", 32'(active), 32'd0);
        next();

        // Reset while in WAIT_DONE.
        req_valid = 4'b0100;
        @(negedge clock);
        check("mrst_ready", 32'(req_ready), 32'b0100);
        next();
        req_valid = 4'b0000;
        @(negedge clock);
        check("mrst_start", 32'(tx_start), 32'd1);
        next();
        tx_busy = 1'b1;
        next();
        @(negedge clock);
        check("mrst_wait_done_active", 32'(active), 32'd1);
        reset    = 1'b0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        next();
        tx_busy = 1'b0;
        @(negedge clock);
        check("mrst_tx_start", 32'(tx_start), 32'd0);
        check("mrst_tx_data", 32'(tx_data), 32'h00);
        check("mrst_grant_id", 32'(grant_id), 32'd0);
        check("mrst_timeout_err", 32'(timeout_err), 32'd0);
        check("mrst_active", 32'(active), 32'd0);
        check("mrst_req_ready", 32'(req_ready), 32'd0);
        next();
        reset     = 1'b1;
        req_valid = 4'b1111;
        @(negedge clock);
        check("mrst_first_ready", 32'(req_ready), 32'b0001);

        // Round robin with all four requesters valid and 10-cycle frames.
        for (int f = 0; f < 5; f++) begin
            seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                next();
                tx_busy = 1'b0;
                @(negedge clock);
                if (tx_start) begin
                    seen = 1'b1;
                    break;
                end
            end
            check($sformatf("rr%0d_start_seen", f), 32'(seen), 32'd1);
            check($sformatf("rr%0d_data", f), 32'(tx_data), 32'(rr_exp[f]));
            for (int b = 0; b < 10; b++) begin
                next();
                tx_busy = 1'b1;
                @(negedge clock);
                check($sformatf("rr%0d_b%0d_no_start", f, b), 32'(tx_start), 32'd0);
            end
        end
        next();
        tx_busy   = 1'b0;
        req_valid = 4'b0000;
        repeat (3) next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
